// File: rtl/qlen_gen.sv
// Splits a flat data stream into queue transactions whose lengths come from a length stream.
// dout carries {len eot bits, innermost eot, data} and forms a (LEN_LVL+1)-level queue.
module qlen_gen #(
  parameter int TDIN    = 16,
  parameter int W_LEN   = 16,
  parameter int LEN_LVL = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       din_valid,
  output logic                       din_ready,
  input  logic [TDIN-1:0]            din_data,
  input  logic                       len_valid,
  output logic                       len_ready,
  input  logic [LEN_LVL+W_LEN-1:0]   len_data,
  output logic                       dout_valid,
  input  logic                       dout_ready,
  output logic [LEN_LVL+TDIN:0]      dout_data
);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t             state;
  logic [W_LEN-1:0]   len_reg;
  logic [W_LEN-1:0]   cnt;
  logic [LEN_LVL-1:0] eot_reg;

  logic [W_LEN-1:0]   len_cnt;
  logic [LEN_LVL-1:0] len_eot;
  logic               len_zero;
  logic               run;
  logic               last;
  logic               dout_hs;

  assign len_cnt  = len_data[W_LEN-1:0];
  assign len_eot  = len_data[LEN_LVL+W_LEN-1:W_LEN];
  assign len_zero = (len_cnt == '0);
  assign run      = (state == RUN);
  assign last     = run && (cnt == len_reg - W_LEN'(1));

  // Reset masks every ready/valid so no item or length word changes hands in the reset cycle.
  assign dout_valid = din_valid && run && !rst;
  assign din_ready  = dout_ready && run && !rst;
  assign dout_hs    = dout_valid && dout_ready;
  assign len_ready  = !rst && (!run || (last && dout_hs));
  assign dout_data  = {eot_reg, last, din_data};

  // NOTE: all state below uses non-blocking assignments so every register sees pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      len_reg <= '0;
      eot_reg <= '0;
    end else begin
      case (state)
        IDLE: begin
          // A zero-length word is consumed here and simply dropped.
          if (len_valid && !len_zero) begin
            len_reg <= len_cnt;
            eot_reg <= len_eot;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          if (dout_hs) begin
            if (!last) begin
              cnt <= cnt + W_LEN'(1);
            end else if (len_valid && !len_zero) begin
              len_reg <= len_cnt;
              eot_reg <= len_eot;
              cnt     <= '0;
            end else begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_qlen_gen.sv
// Bench for qlen_gen: directed timing cases plus randomized streams scored against a
// packet-level model (length words expand into per-item eot tags paired with din order).
module tb_qlen_gen;

  localparam int TDIN    = 8;
  localparam int W_LEN   = 4;
  localparam int LEN_LVL = 1;
  localparam int WL      = LEN_LVL + W_LEN;
  localparam int WO      = LEN_LVL + 1 + TDIN;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic            din_valid = 1'b0;
  logic            din_ready;
  logic [TDIN-1:0] din_data = '0;
  logic            len_valid = 1'b0;
  logic            len_ready;
  logic [WL-1:0]   len_data = '0;
  logic            dout_valid;
  logic            dout_ready = 1'b0;
  logic [WO-1:0]   dout_data;

  always #5 clk = ~clk;

  qlen_gen #(.TDIN(TDIN), .W_LEN(W_LEN), .LEN_LVL(LEN_LVL)) dut (
    .clk       (clk),
    .rst       (rst),
    .din_valid (din_valid),
    .din_ready (din_ready),
    .din_data  (din_data),
    .len_valid (len_valid),
    .len_ready (len_ready),
    .len_data  (len_data),
    .dout_valid(dout_valid),
    .dout_ready(dout_ready),
    .dout_data (dout_data)
  );

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;
  int p_len = 100;
  int p_din = 100;
  int p_rdy = 100;

  logic [WL-1:0]      len_q[$];
  logic [TDIN-1:0]    din_q[$];
  logic [TDIN-1:0]    dref_q[$];
  logic [LEN_LVL:0]   tag_q[$];
  int                 out_cyc[$];
  int                 len_cyc[$];
  logic               lr_q[$];
  int                 rt_exp[$];
  int                 rt_got[$];
  int                 rt_cnt = 0;
  logic [TDIN-1:0]    next_data = '0;
  logic               len_hs_seen = 1'b0;
  logic               din_hs_seen = 1'b0;
  logic               prev_stall = 1'b0;
  logic [WO-1:0]      prev_data = '0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_vec++;
    if (got !== want) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, want, cyc);
    end
  endtask

  // Reference model: a length word of L>0 yields L tags {eot, item==L-1}; zero words yield none.
  task automatic add_len(input logic [LEN_LVL-1:0] eot, input int l);
    len_q.push_back({eot, W_LEN'(l)});
    for (int i = 0; i < l; i++) tag_q.push_back({eot, i == l - 1});
  endtask

  task automatic add_data(input int n);
    for (int i = 0; i < n; i++) begin
      din_q.push_back(next_data);
      dref_q.push_back(next_data);
      next_data++;
    end
  endtask

  task automatic pkt(input logic [LEN_LVL-1:0] eot, input int l);
    add_len(eot, l);
    add_data(l);
  endtask

  task automatic clear_logs();
    out_cyc.delete();
    len_cyc.delete();
    lr_q.delete();
  endtask

  task automatic monitor();
    logic          dout_hs;
    logic [WO-1:0] want;
    @(negedge clk);
    cyc++;
    dout_hs = dout_valid && dout_ready;
    if (!dout_ready) check("din_ready_stall", din_ready, 0);
    if (!din_valid) check("valid_without_din", dout_valid, 0);
    else            check("hs_passthrough", din_ready, dout_ready && dout_valid);
    if (prev_stall && dout_valid) check("stall_stable", dout_data, prev_data);
    prev_stall = dout_valid && !dout_ready;
    prev_data  = dout_data;
    if (dout_hs) begin
      out_cyc.push_back(cyc);
      lr_q.push_back(len_ready);
      if (tag_q.size() == 0 || dref_q.size() == 0) begin
        check("dout_unexpected", dout_valid, 0);
      end else begin
        want = {tag_q.pop_front(), dref_q.pop_front()};
        check("dout", dout_data, want);
      end
      rt_cnt++;
      if (&dout_data[WO-1:TDIN]) begin
        rt_got.push_back(rt_cnt);
        rt_cnt = 0;
      end
    end
    if (len_valid && len_ready) len_cyc.push_back(cyc);
    len_hs_seen = len_valid && len_ready;
    din_hs_seen = din_valid && din_ready;
  endtask

  // Sources keep valid and data stable until handshaked; ready is free to toggle.
  task automatic drive();
    if (len_hs_seen) void'(len_q.pop_front());
    if (din_hs_seen) void'(din_q.pop_front());
    if (!(len_valid && !len_hs_seen)) begin
      len_valid = (len_q.size() > 0) && ($urandom_range(99) < p_len);
      len_data  = '0;
      if (len_valid) len_data = len_q[0];
    end
    if (!(din_valid && !din_hs_seen)) begin
      din_valid = (din_q.size() > 0) && ($urandom_range(99) < p_din);
      din_data  = '0;
      if (din_valid) din_data = din_q[0];
    end
    dout_ready  = ($urandom_range(99) < p_rdy);
    len_hs_seen = 1'b0;
    din_hs_seen = 1'b0;
  endtask

  task automatic cycle();
    monitor();
    @(posedge clk);
    #1;
    drive();
  endtask

  task automatic run_drain(input string name, input int budget);
    for (int i = 0; i < budget && tag_q.size() > 0; i++) cycle();
    check({name, "_drain_left"}, tag_q.size(), 0);
    repeat (3) cycle();
  endtask

  // Probes IDLE: a waiting din item must neither pass nor be accepted, and len must be open.
  task automatic check_idle(input string name);
    len_valid  = 1'b0;
    din_valid  = 1'b1;
    din_data   = 8'h5A;
    dout_ready = 1'b1;
    @(negedge clk);
    check({name, "_dout_valid"}, dout_valid, 0);
    check({name, "_din_ready"}, din_ready, 0);
    check({name, "_len_ready"}, len_ready, 1);
    @(posedge clk);
    #1;
    din_valid  = 1'b0;
    din_data   = '0;
    prev_stall = 1'b0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    monitor();
    check("rst_din_ready", din_ready, 0);
    check("rst_dout_valid", dout_valid, 0);
    tag_q.delete();
    rt_cnt = 0;
    clear_logs();
    @(posedge clk);
    #1;
    rst = 1'b0;
    drive();
  endtask

  initial begin
    int nw, sum, l;

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check_idle("reset");

    // Basic: one packet of 3 at full rate.
    clear_logs();
    next_data = 8'h0A;
    pkt(1'b1, 3);
    drive();
    run_drain("basic", 50);
    check("basic_count", out_cyc.size(), 3);
    check("basic_len_count", len_cyc.size(), 1);
    if (out_cyc.size() == 3 && len_cyc.size() == 1) begin
      check("basic_first_latency", out_cyc[0] - len_cyc[0], 1);
      check("basic_gap1", out_cyc[1] - out_cyc[0], 1);
      check("basic_gap2", out_cyc[2] - out_cyc[1], 1);
      check("basic_len_ready_mid", lr_q[0], 0);
      check("basic_len_ready_last", lr_q[2], 1);
    end

    // Back-to-back with a zero-length word in between.
    clear_logs();
    next_data = 8'h01;
    pkt(1'b0, 2);
    add_len(1'b0, 0);
    pkt(1'b1, 1);
    drive();
    run_drain("zero", 50);
    check("zero_count", out_cyc.size(), 3);
    check("zero_len_count", len_cyc.size(), 3);
    if (out_cyc.size() == 3 && len_cyc.size() == 3) begin
      check("zero_gap1", out_cyc[1] - out_cyc[0], 1);
      check("zero_gap2", out_cyc[2] - out_cyc[1], 2);
      check("zero_word_at_last", len_cyc[1], out_cyc[1]);
    end

    // Backpressure on dout.
    clear_logs();
    p_rdy = 50;
    pkt(1'b0, 4);
    drive();
    run_drain("bp", 200);
    check("bp_count", out_cyc.size(), 4);

    // Maximum length for W_LEN=4.
    clear_logs();
    p_rdy = 70;
    pkt(1'b1, 15);
    drive();
    run_drain("max", 400);
    check("max_count", out_cyc.size(), 15);
    if (out_cyc.size() == 15) check("max_len_ready_last", lr_q[14], 1);
    check_idle("max_idle");

    // Reset after two items of a 5-item packet, then a 2-item packet.
    clear_logs();
    p_rdy = 100;
    pkt(1'b0, 5);
    drive();
    for (int i = 0; i < 50 && out_cyc.size() < 2; i++) cycle();
    check("rst_pre_items", out_cyc.size(), 2);
    reset_dut();
    add_len(1'b1, 2);
    drive();
    run_drain("rst_next", 50);
    check("rst_next_count", out_cyc.size(), 2);
    check("rst_din_left", din_q.size(), 1);
    din_q.delete();
    dref_q.delete();
    din_valid = 1'b0;
    din_data  = '0;
    check_idle("rst_idle");

    // Round trip: outer packets made of random length words; per-outer item totals must match.
    clear_logs();
    rt_got.delete();
    rt_exp.delete();
    rt_cnt = 0;
    p_len  = 70;
    p_din  = 70;
    p_rdy  = 60;
    for (int o = 0; o < 10; o++) begin
      nw  = $urandom_range(1, 4);
      sum = 0;
      for (int w = 0; w < nw; w++) begin
        if ($urandom_range(99) < 20) add_len(1'b0, 0);
        l = $urandom_range(1, 15);
        pkt(w == nw - 1, l);
        sum += l;
      end
      rt_exp.push_back(sum);
    end
    drive();
    run_drain("rt", 8000);
    check("rt_outer_count", rt_got.size(), rt_exp.size());
    for (int i = 0; i < rt_exp.size() && i < rt_got.size(); i++)
      check($sformatf("rt_outer_len_%0d", i), rt_got[i], rt_exp[i]);
    check("rt_len_left", len_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
